// File: rtl/brief_desc_packer.sv
// Queues BRIEF keypoint records and frame markers from the descriptor stage and
// serializes them onto a 32-bit valid/ready stream, with frame and drop counters.
module brief_desc_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pixel_valid,
  input  logic             i_flag,
  input  logic [9:0]       i_coor_x,
  input  logic [9:0]       i_coor_y,
  input  logic [7:0]       i_score,
  input  logic [255:0]     i_descriptor,
  input  logic             i_start,
  input  logic             i_end,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic             o_last,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 286;
  localparam logic [1:0]  TAG_KP   = 2'b01;
  localparam logic [1:0]  TAG_SOF  = 2'b10;
  localparam logic [1:0]  TAG_EOF  = 2'b11;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_t;

  // Entry layout: {tag[1:0], y[9:0], x[9:0], score[7:0], descriptor[255:0]}
  function automatic logic [31:0] word_of(input logic [EW-1:0] e, input logic [3:0] k);
    logic [7:0][31:0] desc;
    logic [31:0]      w;
    desc = e[255:0];
    w    = 32'h0000_0000;
    case (e[EW-1 -: 2])
      TAG_SOF: w = 32'h8000_0000;
      TAG_EOF: w = {2'b11, 14'b0, 16'(e[CNT_W-1:0])};
      TAG_KP: begin
        if (k == 4'd0) w = {2'b01, e[283:264], e[263:256], 2'b00};
        else           w = desc[3'(k - 4'd1)];
      end
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic last_of(input logic [1:0] tag, input logic [3:0] k);
    return (tag == TAG_KP) ? (k == 4'd8) : 1'b1;
  endfunction

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q;
  logic             full_s, empty_s, push_s, pop_s;
  logic             kp_wr_s, eof_wr_s, sof_wr_s;
  logic [EW-1:0]    wr_entry_s, head_s;
  logic             pend_eof_q, pend_eof_d, pend_sof_q, pend_sof_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  state_t           state_q;
  logic [EW-1:0]    hold_q;
  logic [3:0]       idx_q, nidx_s;
  logic [31:0]      data_q;
  logic             valid_q, last_q;

  assign full_s  = (fill_q == FULL_LVL);
  assign empty_s = (fill_q == {(AW+1){1'b0}});
  assign head_s  = mem_q[rd_ptr_q];
  assign pop_s   = (state_q != S_SEND) && !empty_s;
  assign push_s  = kp_wr_s | eof_wr_s | sof_wr_s;
  assign nidx_s  = idx_q + 4'd1;

  // Capture arbitration: older pending markers first, then keypoint, then fresh markers
  always_comb begin
    eof_wr_s    = 1'b0;
    sof_wr_s    = 1'b0;
    kp_wr_s     = 1'b0;
    wr_entry_s  = {EW{1'b0}};
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (i_pixel_valid && !full_s) begin
      if (pend_eof_q)      eof_wr_s = 1'b1;
      else if (pend_sof_q) sof_wr_s = 1'b1;
      else if (i_flag)     kp_wr_s  = 1'b1;
      else if (i_end)      eof_wr_s = 1'b1;
      else if (i_start)    sof_wr_s = 1'b1;
      else                 kp_wr_s  = 1'b0;
    end else begin
      kp_wr_s = 1'b0;
    end
    // A marker written straight from the input never becomes pending
    pend_eof_d = (pend_eof_q & ~eof_wr_s) | (i_pixel_valid & i_end & ~(eof_wr_s & ~pend_eof_q));
    pend_sof_d = (pend_sof_q & ~sof_wr_s) | (i_pixel_valid & i_start & ~(sof_wr_s & ~pend_sof_q));
    if (kp_wr_s) begin
      wr_entry_s = {TAG_KP, i_coor_y, i_coor_x, i_score, i_descriptor};
      if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      else                              frame_cnt_d = frame_cnt_q;
    end else if (eof_wr_s) begin
      wr_entry_s[EW-1 -: 2]   = TAG_EOF;
      wr_entry_s[CNT_W-1:0]   = frame_cnt_q;
    end else if (sof_wr_s) begin
      wr_entry_s[EW-1 -: 2] = TAG_SOF;
      frame_cnt_d           = {CNT_W{1'b0}};
    end else begin
      wr_entry_s = {EW{1'b0}};
    end
    if (i_pixel_valid && i_flag && !kp_wr_s && (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    else
      drop_cnt_d = drop_cnt_q;
  end

  // FIFO pointers, occupancy, pending markers and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      fill_q      <= {(AW+1){1'b0}};
      pend_eof_q  <= 1'b0;
      pend_sof_q  <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
      drop_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q      <= fill_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
      pend_eof_q  <= pend_eof_d;
      pend_sof_q  <= pend_sof_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_entry_s;
  end

  // Output FSM; an idle engine loads directly so a fresh entry shows two cycles after capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= {EW{1'b0}};
      idx_q   <= 4'd0;
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (!empty_s) begin
            hold_q  <= head_s;
            idx_q   <= 4'd0;
            data_q  <= word_of(head_s, 4'd0);
            last_q  <= last_of(head_s[EW-1 -: 2], 4'd0);
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end else begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SEND: begin
          if (valid_q && i_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= empty_s ? S_IDLE : S_LOAD;
            end else begin
              idx_q  <= nidx_s;
              data_q <= word_of(hold_q, nidx_s);
              last_q <= last_of(hold_q[EW-1 -: 2], nidx_s);
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_busy     = !empty_s | valid_q | pend_eof_q | pend_sof_q;

endmodule

// File: tb/tb_brief_desc_packer.sv
// Scoreboard bench: an input-side model queues expected words, a negedge monitor
// compares every accepted output word and checks that stalled words hold steady.
module tb_brief_desc_packer;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_pixel_valid = 1'b0;
  logic         i_flag = 1'b0;
  logic [9:0]   i_coor_x = 10'd0;
  logic [9:0]   i_coor_y = 10'd0;
  logic [7:0]   i_score = 8'd0;
  logic [255:0] i_descriptor = 256'd0;
  logic         i_start = 1'b0;
  logic         i_end = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [31:0]  o_data;
  logic         o_last;
  logic [15:0]  o_drop_cnt;
  logic         o_busy;

  brief_desc_packer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pixel_valid(i_pixel_valid), .i_flag(i_flag),
    .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score), .i_descriptor(i_descriptor),
    .i_start(i_start), .i_end(i_end), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  int          tests = 0;
  int          fails = 0;
  int          words_seen = 0;
  int          cycle_no = 0;
  int          rdy_mode = 0;
  int          m_space = 1000000;
  logic [3:0]  rdy_pat = 4'b1001;
  logic [32:0] exp_q[$];
  bit          plist[$];
  logic [15:0] m_cnt = 16'd0;
  logic [15:0] m_drop = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the host must see, derived from the capture rules
  task automatic emit_marker(input bit is_eof);
    if (is_eof) exp_q.push_back({1'b1, 2'b11, 14'd0, m_cnt});
    else begin
      exp_q.push_back({1'b1, 32'h8000_0000});
      m_cnt = 16'd0;
    end
    m_space--;
  endtask

  task automatic emit_kp(input logic [9:0] x, input logic [9:0] y, input logic [7:0] s,
                         input logic [255:0] d);
    exp_q.push_back({1'b0, 2'b01, y, x, s, 2'b00});
    for (int k = 1; k <= 8; k++) exp_q.push_back({(k == 8), d[32*k-1 -: 32]});
    if (m_cnt != 16'hFFFF) m_cnt++;
    m_space--;
  endtask

  task automatic note_drop();
    if (m_drop != 16'hFFFF) m_drop++;
  endtask

  task automatic model_step(input bit pv, input bit fl, input bit st, input bit en,
                            input logic [9:0] x, input logic [9:0] y, input logic [7:0] s,
                            input logic [255:0] d);
    bit wrote;
    if (!pv) return;
    wrote = 1'b0;
    if (plist.size() > 0) begin
      if (fl) note_drop();
      if (m_space > 0) begin
        emit_marker(plist.pop_front());
        wrote = 1'b1;
      end
    end else if (fl) begin
      if (m_space > 0) begin
        emit_kp(x, y, s, d);
        wrote = 1'b1;
      end else note_drop();
    end
    if (en) plist.push_back(1'b1);
    if (st) plist.push_back(1'b0);
    if (!wrote && plist.size() > 0 && m_space > 0) emit_marker(plist.pop_front());
  endtask

  task automatic cyc(input bit pv, input bit fl, input bit st, input bit en,
                     input logic [9:0] x, input logic [9:0] y, input logic [7:0] s,
                     input logic [255:0] d);
    i_pixel_valid = pv; i_flag = fl; i_start = st; i_end = en;
    i_coor_x = x; i_coor_y = y; i_score = s; i_descriptor = d;
    case (rdy_mode)
      1:       i_ready = ($urandom_range(0, 3) != 0);
      2:       i_ready = 1'b0;
      3:       i_ready = rdy_pat[cycle_no % 4];
      default: i_ready = 1'b1;
    endcase
    model_step(pv, fl, st, en, x, y, s, d);
    @(posedge i_clk);
    #1;
    cycle_no++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0, 256'd0);
  endtask

  task automatic rand_kp(output logic [9:0] x, output logic [9:0] y, output logic [7:0] s,
                         output logic [255:0] d);
    x = 10'($urandom_range(0, 1023));
    y = 10'($urandom_range(0, 1023));
    s = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      idle(1);
      n++;
    end
    idle(4);
    chk(name, exp_q.size(), 32'd0);
  endtask

  // Monitor: compare each accepted word, and require stalled words to stay frozen
  initial begin : monitor
    bit          stalled;
    logic [32:0] held;
    logic [32:0] e;
    stalled = 1'b0;
    held    = 33'd0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) stalled = 1'b0;
      else begin
        if (stalled) begin
          tests++;
          if (!o_valid || {o_last, o_data} !== held) begin
            fails++;
            $display("FAIL hold: got valid=%0b word=%h, expected valid=1 word=%h",
                     o_valid, {o_last, o_data}, held);
          end
        end
        if (o_valid && i_ready) begin
          words_seen++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL word: got unexpected %h, expected no word", {o_last, o_data});
          end else begin
            e = exp_q.pop_front();
            if ({o_last, o_data} !== e) begin
              fails++;
              $display("FAIL word: got last/data %h, expected %h", {o_last, o_data}, e);
            end
          end
        end
        stalled = o_valid && !i_ready;
        held    = {o_last, o_data};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [9:0]   x, y;
    logic [7:0]   s;
    logic [255:0] d;
    int           base;
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst valid", o_valid, 32'd0);
    chk("rst data", o_data, 32'd0);
    chk("rst last", o_last, 32'd0);
    chk("rst drop", o_drop_cnt, 32'd0);
    chk("rst busy", o_busy, 32'd0);

    // Single keypoint frame with latency checks
    rdy_mode = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 256'd0);
    chk("lat n+1 valid", o_valid, 32'd0);
    d = 256'd1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 10'd5, 10'd7, 8'h3C, d);
    chk("lat n+2 valid", o_valid, 32'd1);
    chk("lat n+2 data", o_data, 32'h8000_0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'd0, 256'd0);
    drain("single drain");

    // Back-pressure during one keypoint
    rdy_mode = 3;
    base = words_seen;
    rand_kp(x, y, s, d);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, x, y, s, d);
    drain("bp drain");
    chk("bp words", words_seen - base, 32'd9);

    // Overflow: SOF parked in the output register, then ten keypoints into eight slots
    rdy_mode = 2;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 256'd0);
    idle(1);
    m_space = 8;
    for (int i = 0; i < 10; i++) begin
      rand_kp(x, y, s, d);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, x, y, s, d);
    end
    chk("ovf drop", o_drop_cnt, 32'(m_drop));
    chk("ovf drop abs", o_drop_cnt, 32'd2);
    chk("ovf busy", o_busy, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'd0, 256'd0);
    m_space = 1000000;
    rdy_mode = 0;
    drain("ovf drain");

    // Keypoint + end + start together, then a keypoint that must be dropped
    rand_kp(x, y, s, d);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, x, y, s, d);
    rand_kp(x, y, s, d);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, x, y, s, d);
    drain("coin drain");
    chk("coin drop", o_drop_cnt, 32'(m_drop));

    // Inputs ignored while i_pixel_valid is low
    for (int i = 0; i < 3; i++) begin
      rand_kp(x, y, s, d);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, x, y, s, d);
    end
    idle(3);
    chk("pv0 busy", o_busy, 32'd0);
    chk("pv0 drop", o_drop_cnt, 32'(m_drop));

    // Randomized traffic with random back-pressure
    rdy_mode = 1;
    for (int ev = 0; ev < 40; ev++) begin
      bit fl, st, en;
      fl = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 2);
      en = ($urandom_range(0, 9) < 2);
      rand_kp(x, y, s, d);
      cyc(1'b1, fl, st, en, x, y, s, d);
      if ($urandom_range(0, 3) == 0) begin
        rand_kp(x, y, s, d);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, x, y, s, d);
      end
      idle($urandom_range(40, 50));
    end
    drain("rand drain");
    chk("rand drop", o_drop_cnt, 32'(m_drop));
    chk("rand busy", o_busy, 32'd0);

    // Asynchronous reset while word 4 of a keypoint is on the bus
    rdy_mode = 0;
    base = words_seen;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 256'd0);
    rand_kp(x, y, s, d);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, x, y, s, d);
    for (int i = 0; i < 50 && words_seen < base + 5; i++) idle(1);
    chk("pre-rst words", words_seen - base, 32'd5);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst valid", o_valid, 32'd0);
    chk("arst drop", o_drop_cnt, 32'd0);
    chk("arst busy", o_busy, 32'd0);
    exp_q.delete();
    plist.delete();
    m_cnt = 16'd0;
    m_drop = 16'd0;
    m_space = 1000000;
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'd0, 256'd0);
    idle(1);
    chk("post-rst valid", o_valid, 32'd1);
    chk("post-rst sof", o_data, 32'h8000_0000);
    drain("post-rst drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
